aes_128_dec_iter: RTL
=====================

Name: aes_128_dec_iter

Overview:
- Iterative AES-128 decryptor: the inverse-cipher counterpart of the aes_128 encryption pipeline.
- Takes the cipher key and a 128-bit ciphertext.
  - Expands the key forward to round key 10.
  - Runs 10 inverse rounds, one per cycle, rolling the key schedule backwards on the fly.
- Sits beside aes_128 in the equivalence harness, so that dec(enc(x)) == x can be checked formally and in simulation.

Parameters:
- NR, 10, number of rounds; fixed for AES-128. Any other value is unsupported and triggers an elaboration-time error.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request. Sampled only in IDLE or DONE.
- key  input  128  cipher key, FIPS-197 byte order (byte0 = [127:120]). Captured when start is accepted.
- ct  input  128  ciphertext, same byte order. Captured when start is accepted.
- busy  output  1  high while a decryption is in flight (KEYEXP or ROUND)
- done  output  1  one-cycle pulse: pt is valid
- pt  output  128  plaintext. Held from done until the next accepted start.

Behaviour:
- Reset: synchronous on posedge clk. State -> IDLE; busy=0, done=0, pt=0, counter=0, internal key/state regs=0. Reset mid-operation aborts immediately; no done is issued.
- State machine:
  - IDLE: start=1 -> latch key into kreg, ct into sreg, cnt=0, go KEYEXP.
  - KEYEXP (10 cycles, cnt 0..9):
    - Each cycle kreg <= forward expansion step with rcon[cnt] (01,02,04,08,10,20,40,80,1b,36).
    - On cnt=9: sreg <= sreg ^ next_key (round key 10 applied), cnt=0, go ROUND.
  - ROUND (10 cycles, cnt 0..9):
    - Inverse key step: kreg <= previous round key, using rcon[9-cnt].
      - w1' = w0^w1, w2' = w1^w2, w3' = w2^w3
      - w0' = w0 ^ SubWord(RotWord(w3')) ^ rcon
    - cnt 0..8: sreg <= InvMixColumns(InvSubBytes(InvShiftRows(sreg)) ^ kprev).
    - cnt 9: pt <= InvSubBytes(InvShiftRows(sreg)) ^ kprev (equals the original key), with no InvMixColumns; go DONE.
  - DONE (1 cycle): done=1.
    - start=1 -> accepted exactly as in IDLE (back-to-back, no bubble).
    - Otherwise go IDLE.
- busy = (state==KEYEXP || state==ROUND).
- Latency: start accepted at edge E0 -> busy high for exactly 20 cycles -> done high in cycle 21. Throughput is one block per 21 cycles.
- start while busy is ignored. key/ct changes after acceptance have no effect.
- Arithmetic:
  - All operations are GF(2^8) over the polynomial 0x11b.
  - InvMixColumns coefficients are 0e, 0b, 0d, 09, built from xtime chains.
  - Purely combinational datapath between the kreg/sreg registers. Only one round of logic per cycle: no unrolling.
- pt is only written in the last ROUND cycle. It is never glitched or cleared by IDLE.

Decomposition:
- Shared package aes_pkg holds:
  - NR, the rcon table, and the byte/word typedefs (byte_t, word_t, block_t)
  - functions xtime, gmul09/0b/0d/0e, inv_shift_rows, rot_word
- Forward S-box: reuse the existing S-box module from aes_128. It is needed for the key schedule in both directions (4 instances on w3).
- New sub-module: aes_inv_sbox, a 256-entry byte lookup (16 instances for the state).
- FSM, counters and datapath stay in aes_128_dec_iter.

Test Plan:
- FIPS-197 App. C.1:
  - Stimulus: key=000102030405060708090a0b0c0d0e0f, ct=69c4e0d86a7b0430d8cdb78070b4c55a, start pulse.
  - Required: pt=00112233445566778899aabbccddeeff at done, which is exactly 21 cycles after start.
- FIPS-197 App. B:
  - Stimulus: key=2b7e151628aed2a6abf7158809cf4f3c, ct=3925841d02dc09fbdc118597196a0b32.
  - Required: kreg=d014f9a8c9ee2589e13f0cc8b6630ca6 on KEYEXP exit; pt=3243f6a8885a308d313198a2e0370734.
- Back-to-back:
  - Stimulus: start held high for the whole run with the C.1 vectors, then the B vectors asserted in the DONE cycle.
  - Required: second done exactly 21 cycles after the first; start inputs during busy are ignored.
- Reset mid-operation:
  - Stimulus: rst=1 at ROUND cnt=4.
  - Required: next cycle busy=0, done=0, pt=0, state IDLE. No done is issued until a new start.
- Harness equivalence:
  - Stimulus: random key/pt into aes_128; feed its output to aes_128_dec_iter.
  - Required: assert done |-> pt == delayed pt, over ≥10k random vectors, plus a formal proof in the vtop-style harness.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers.
// Used by the S-boxes, the interface and the iterative decryptor.
package aes_pkg;

    localparam int NR = 10;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        IDLE,
        KEYEXP,
        ROUND,
        DONE
    } state_t;

    localparam logic [0:9][7:0] RCON = 80'h01020408102040801b36;

    function automatic byte_t rcon(input logic [3:0] i);
        return (i < 4'd10) ? RCON[i] : 8'h00;
    endfunction

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gmul09(input byte_t b);
        byte_t x8;
        x8 = xtime(xtime(xtime(b)));
        return x8 ^ b;
    endfunction

    function automatic byte_t gmul0b(input byte_t b);
        byte_t x2;
        x2 = xtime(b);
        return xtime(xtime(x2)) ^ x2 ^ b;
    endfunction

    function automatic byte_t gmul0d(input byte_t b);
        byte_t x4;
        x4 = xtime(xtime(b));
        return xtime(x4) ^ x4 ^ b;
    endfunction

    function automatic byte_t gmul0e(input byte_t b);
        byte_t x2;
        byte_t x4;
        x2 = xtime(b);
        x4 = xtime(x2);
        return xtime(x4) ^ x4 ^ x2;
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    // Byte i of the block sits at [127-8i -: 8]; row r, column c is
    // byte 4c+r. Row r rotates right by r positions.
    function automatic block_t inv_shift_rows(input block_t s);
        block_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] =
                    s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic word_t inv_mix_col(input word_t w);
        byte_t a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {
            gmul0e(a0) ^ gmul0b(a1) ^ gmul0d(a2) ^ gmul09(a3),
            gmul09(a0) ^ gmul0e(a1) ^ gmul0b(a2) ^ gmul0d(a3),
            gmul0d(a0) ^ gmul09(a1) ^ gmul0e(a2) ^ gmul0b(a3),
            gmul0b(a0) ^ gmul0d(a1) ^ gmul09(a2) ^ gmul0e(a3)
        };
    endfunction

    function automatic block_t inv_mix_columns(input block_t s);
        block_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_128_dec_iter_if.sv
// Request/response bundle of the iterative AES-128 decryptor.
// master: start, key, ct out; busy, done, pt in. slave: reverse.
interface aes_128_dec_iter_if;
    import aes_pkg::*;

    logic   start;
    block_t key;
    block_t ct;
    logic   busy;
    logic   done;
    block_t pt;

    modport master (
        output start, key, ct,
        input  busy, done, pt
    );

    modport slave (
        input  start, key, ct,
        output busy, done, pt
    );

endinterface

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box (InvSubBytes on one byte).
// Ports: a = input byte, y = InvSubBytes(a).
module aes_inv_sbox
    import aes_pkg::*;
(
    input  byte_t a,
    output byte_t y
);

    localparam logic [0:255][7:0] ISBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign y = ISBOX[a];

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box, shared with the aes_128 encryptor.
// Ports: a = input byte, y = SubBytes(a).
module aes_sbox
    import aes_pkg::*;
(
    input  byte_t a,
    output byte_t y
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX[a];

endmodule

// File: rtl/aes_128_dec_iter.sv
// Iterative AES-128 decryptor: 10 key-expansion cycles, then 10
// inverse rounds rolling the key schedule backwards on the fly.
// Ports: clk, rst (sync, active-high), bus (slave): start/key/ct in,
// busy/done/pt out.
module aes_128_dec_iter
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input logic            clk,
    input logic            rst,
    aes_128_dec_iter_if.slave bus
);

    if (NR != 10) begin : g_nr_check
        $error("aes_128_dec_iter supports NR == 10 only");
    end

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    block_t     kreg, kreg_n;
    block_t     sreg, sreg_n;
    block_t     pt_q, pt_n;

    logic       accept;
    word_t      w0, w1, w2, w3;
    word_t      p0, p1, p2, p3;
    word_t      n0, n1, n2, n3;
    word_t      sb_in, sb_out, rw;
    logic [3:0] rc_idx;
    block_t     key_fwd, key_inv;
    block_t     isr, isb, ark;

    assign accept = bus.start && (state == IDLE || state == DONE);

    // Key schedule: the same four S-boxes serve both directions; the
    // backward step substitutes the reconstructed w3' instead of w3.
    assign {w0, w1, w2, w3} = kreg;
    assign p1 = w0 ^ w1;
    assign p2 = w1 ^ w2;
    assign p3 = w2 ^ w3;
    assign sb_in  = (state == ROUND) ? p3 : w3;
    assign rc_idx = (state == ROUND) ? 4'd9 - cnt : cnt;
    assign rw = rot_word(sb_out) ^ {rcon(rc_idx), 24'h0};

    for (genvar i = 0; i < 4; i++) begin : g_ksb
        aes_sbox u_sbox (
            .a (sb_in[8*i +: 8]),
            .y (sb_out[8*i +: 8])
        );
    end

    assign n0 = w0 ^ rw;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign p0 = w0 ^ rw;
    assign key_fwd = {n0, n1, n2, n3};
    assign key_inv = {p0, p1, p2, p3};

    assign isr = inv_shift_rows(sreg);

    for (genvar i = 0; i < 16; i++) begin : g_isb
        aes_inv_sbox u_inv_sbox (
            .a (isr[8*i +: 8]),
            .y (isb[8*i +: 8])
        );
    end

    assign ark = isb ^ key_inv;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        kreg_n  = kreg;
        sreg_n  = sreg;
        pt_n    = pt_q;
        unique case (state)
            IDLE, DONE: begin
                if (accept) begin
                    kreg_n  = bus.key;
                    sreg_n  = bus.ct;
                    cnt_n   = 4'd0;
                    state_n = KEYEXP;
                end else begin
                    state_n = IDLE;
                end
            end
            KEYEXP: begin
                kreg_n = key_fwd;
                cnt_n  = cnt + 4'd1;
                if (cnt == 4'd9) begin
                    sreg_n  = sreg ^ key_fwd;
                    cnt_n   = 4'd0;
                    state_n = ROUND;
                end
            end
            ROUND: begin
                kreg_n = key_inv;
                cnt_n  = cnt + 4'd1;
                if (cnt == 4'd9) begin
                    pt_n    = ark;
                    cnt_n   = 4'd0;
                    state_n = DONE;
                end else begin
                    sreg_n = inv_mix_columns(ark);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            kreg  <= '0;
            sreg  <= '0;
            pt_q  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            kreg  <= kreg_n;
            sreg  <= sreg_n;
            pt_q  <= pt_n;
        end
    end

    assign bus.busy = (state == KEYEXP) || (state == ROUND);
    assign bus.done = (state == DONE);
    assign bus.pt   = pt_q;

endmodule
